// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for pipe_stage_elastic: upstream (in_*) and downstream (out_*) sides.
// master = surrounding pipeline, slave = the stage itself.
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 128,
    parameter int DST_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_we;
    logic [DST_W-1:0]  in_dst;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_we;
    logic [DST_W-1:0]  out_dst;

    modport master (
        output in_valid, in_data, in_we, in_dst, out_ready,
        input  in_ready, out_valid, out_data, out_we, out_dst
    );

    modport slave (
        input  in_valid, in_data, in_we, in_dst, out_ready,
        output in_ready, out_valid, out_data, out_we, out_dst
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage holding a MAIN (head) entry and, with PIPE_STAGE_SKID_EN defined,
// a SKID entry so that in_ready comes from a register instead of from out_ready.
module pipe_stage_elastic #(
    parameter int DATA_W = 128,
    parameter int DST_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 hlt,
    pipe_stage_elastic_if.slave  bus,
    output logic [1:0]           occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              we;
        logic [DST_W-1:0]  dst;
    } entry_t;

    localparam entry_t ENTRY_CLEAR = '0;

    state_t state;
    state_t state_n;
    entry_t main_q;
    entry_t main_n;
    entry_t in_entry;
    logic   accept;
    logic   pop;

    assign in_entry      = {bus.in_data, bus.in_we, bus.in_dst};
    assign bus.out_valid = (state != EMPTY) & ~hlt;
    assign bus.out_data  = main_q.data;
    assign bus.out_we    = main_q.we & bus.out_valid;
    assign bus.out_dst   = main_q.dst;
    assign occupancy     = state;
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
    entry_t skid_q;
    entry_t skid_n;
    logic   ready_q;

    // ready_q tracks "next state is not FULL", so upstream never sees out_ready
    assign bus.in_ready = ready_q & ~hlt;
`else
    assign bus.in_ready = ~hlt & (~bus.out_valid | bus.out_ready);
`endif

    always_comb begin
        state_n = state;
        main_n  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_n  = skid_q;
`endif
        if (flush) begin
            state_n = EMPTY;
            main_n  = ENTRY_CLEAR;
`ifdef PIPE_STAGE_SKID_EN
            skid_n  = ENTRY_CLEAR;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n = ONE;
                        main_n  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_n = in_entry;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (accept) begin
                        state_n = FULL;
                        skid_n  = in_entry;
`endif
                    end else if (pop) begin
                        state_n = EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                FULL: begin
                    if (pop) begin
                        state_n = ONE;
                        main_n  = skid_q;
                    end
                end
`endif
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            main_q  <= ENTRY_CLEAR;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= ENTRY_CLEAR;
            ready_q <= 1'b1;
`endif
        end else begin
            state   <= state_n;
            main_q  <= main_n;
`ifdef PIPE_STAGE_SKID_EN
            skid_q  <= skid_n;
            ready_q <= (state_n != FULL);
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios plus randomized traffic
// checked every cycle against a queue-based model; follows PIPE_STAGE_SKID_EN if defined.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 32;
    localparam int DST_W  = 5;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              we;
        logic [DST_W-1:0]  dst;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       hlt;
    logic [1:0] occupancy;

    pipe_stage_elastic_if #(.DATA_W(DATA_W), .DST_W(DST_W)) bus ();

    pipe_stage_elastic #(.DATA_W(DATA_W), .DST_W(DST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .hlt       (hlt),
        .bus       (bus.slave),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;
    ent_t q[$];
    bit   cleared = 1'b1;
    int   accepted_cnt = 0;
    logic m_acc;
    logic m_pop;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic exp_in_ready();
        if (hlt) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || bus.out_ready;
`endif
    endfunction

    // Reference: the stage is a FIFO of capacity CAP; rst and flush empty it, hlt freezes it
    always @(posedge clk) begin
        if (rst || flush) begin
            q.delete();
            cleared = 1'b1;
        end else if (!hlt) begin
            m_acc = bus.in_valid && exp_in_ready();
            m_pop = (q.size() > 0) && bus.out_ready;
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                q.push_back({bus.in_data, bus.in_we, bus.in_dst});
                accepted_cnt++;
                cleared = 1'b0;
            end
        end
    end

    task automatic check_output();
        logic ev;
        ev = !hlt && (q.size() > 0);
        check("occupancy", 64'(occupancy), 64'(q.size()));
        check("out_valid", 64'(bus.out_valid), 64'(ev));
        check("in_ready", 64'(bus.in_ready), 64'(exp_in_ready()));
        check("out_we", 64'(bus.out_we), ev ? 64'(q[0].we) : 64'd0);
        if (ev) begin
            check("out_data", 64'(bus.out_data), 64'(q[0].data));
            check("out_dst", 64'(bus.out_dst), 64'(q[0].dst));
        end else if (q.size() == 0 && cleared) begin
            check("out_data_clear", 64'(bus.out_data), 64'd0);
            check("out_dst_clear", 64'(bus.out_dst), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            #1;
            check_output();
        end
    end

    task automatic apply_stimulus(input logic iv, input logic [DATA_W-1:0] d, input logic we,
                                  input logic [DST_W-1:0] dst, input logic ordy,
                                  input logic h, input logic fl, input logic r);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_we     = we;
        bus.in_dst    = dst;
        bus.out_ready = ordy;
        hlt           = h;
        flush         = fl;
        rst           = r;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int start;
        int cyc;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) tick();
        check_en = 1'b1;

        // Reset state, then release
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_we", 64'(bus.out_we), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_dst", 64'(bus.out_dst), 64'd0);
        tick();
        #2;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single entry, one-cycle latency
        apply_stimulus(1, 32'hA5A5_0001, 1, 7, 1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        check("lat_out_valid", 64'(bus.out_valid), 64'd1);
        check("lat_out_data", 64'(bus.out_data), 64'hA5A5_0001);
        check("lat_out_we", 64'(bus.out_we), 64'd1);
        check("lat_out_dst", 64'(bus.out_dst), 64'd7);
        tick();
        #2;
        check("lat_empty", 64'(occupancy), 64'd0);

        // Back-to-back with a stalled consumer
        apply_stimulus(1, 32'h11, 0, 1, 0, 0, 0, 0);
        #2;
        check("b2b_rdy0", 64'(bus.in_ready), 64'd1);
        tick();
        apply_stimulus(1, 32'h22, 0, 2, 0, 0, 0, 0);
        #2;
        check("b2b_rdy1", 64'(bus.in_ready), (CAP == 2) ? 64'd1 : 64'd0);
        tick();
        apply_stimulus(1, 32'h33, 0, 3, 0, 0, 0, 0);
        #2;
        check("b2b_occ", 64'(occupancy), 64'(CAP));
        check("b2b_rdy2", 64'(bus.in_ready), 64'd0);
        check("b2b_head0", 64'(bus.out_data), 64'h11);
        tick();
        apply_stimulus(1, 32'h33, 0, 3, 1, 0, 0, 0);
        #2;
        check("b2b_head1", 64'(bus.out_data), 64'h11);
        tick();
`ifdef PIPE_STAGE_SKID_EN
        apply_stimulus(1, 32'h33, 0, 3, 1, 0, 0, 0);
        #2;
        check("b2b_head2", 64'(bus.out_data), 64'h22);
        tick();
`endif
        apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        check("b2b_head3", 64'(bus.out_data), 64'h33);
        tick();
        #2;
        check("b2b_drained", 64'(occupancy), 64'd0);

        // Flush while full with a competing accept
        apply_stimulus(1, 32'h44, 1, 3, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 32'h66, 1, 3, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 32'h77, 1, 3, 0, 0, 1, 0);
        #2;
        check("fl_pre_occ", 64'(occupancy), 64'(CAP));
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("fl_occ", 64'(occupancy), 64'd0);
        check("fl_out_valid", 64'(bus.out_valid), 64'd0);
        check("fl_out_we", 64'(bus.out_we), 64'd0);
        check("fl_out_data", 64'(bus.out_data), 64'd0);

        // Halt for three cycles with the consumer ready
        apply_stimulus(1, 32'h55, 1, 2, 0, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 1, 1, 0, 0);
        repeat (3) begin
            #2;
            check("hlt_out_valid", 64'(bus.out_valid), 64'd0);
            check("hlt_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        check("hlt_release_valid", 64'(bus.out_valid), 64'd1);
        check("hlt_release_data", 64'(bus.out_data), 64'h55);
        tick();
        #2;
        check("hlt_once", 64'(bus.out_valid), 64'd0);

        // Reset while full and the consumer is ready
        apply_stimulus(1, 32'h88, 1, 4, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 32'h99, 1, 5, 0, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 1, 0, 0, 1);
        #2;
        check("mrst_pre_occ", 64'(occupancy), 64'(CAP));
        tick();
        apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        check("mrst_occ", 64'(occupancy), 64'd0);
        check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        tick();

        // Randomized traffic
        start = accepted_cnt;
        cyc = 0;
        while ((accepted_cnt - start) < 10000 && cyc < 80000) begin
            apply_stimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 199) == 0), 0);
            tick();
            cyc++;
        end
        checks++;
        if ((accepted_cnt - start) < 10000) begin
            errors++;
            $display("[TB] FAIL random_budget: got %0d accepted, expected 10000", accepted_cnt - start);
        end

        apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0);
        repeat (4) tick();
        #2;
        check("final_drain", 64'(occupancy), 64'd0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
